// File: rtl/booth_digit_accumulator.sv
// Radix-2 Booth digit accumulator: consumes recoded {H,D} digits LSB-first and builds a signed N+M-bit product.
// Optional BOOTH_ERR_EN adds a sticky err output that flags the illegal digit code {H,D}=01.
module booth_digit_accumulator #(
    parameter int N = 3,
    parameter int M = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N-1:0]     multiplicand,
    input  logic             dig_valid,
    input  logic             dig_h,
    input  logic             dig_d,
    output logic             dig_ready,
    output logic             busy,
    output logic             done,
`ifdef BOOTH_ERR_EN
    output logic             err,
`endif
    output logic [N+M-1:0]   prod
);

    localparam int W  = N + M;
    localparam int CW = $clog2(M) + 1;
    localparam logic [CW-1:0] LAST_DIGIT = CW'(M - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t          state_r;
    logic [CW-1:0]   count_r;
    logic [W-1:0]    acc_r;
    logic [W-1:0]    mc_r;

    logic            dig_accept_s;
    logic            last_digit_s;
    logic [W-1:0]    term_s;
    logic [W-1:0]    addend_s;
    logic [W-1:0]    acc_next_s;

    // Signed contribution of one Booth digit; the illegal code 01 contributes nothing.
    function automatic logic [W-1:0] digit_term(input logic h, input logic d, input logic [W-1:0] term);
        logic [W-1:0] result;
        case ({h, d})
            2'b10:   result = term;
            2'b11:   result = {W{1'b0}} - term;
            default: result = {W{1'b0}};
        endcase
        return result;
    endfunction

    // Digit acceptance and next accumulator value.
    always_comb begin
        dig_accept_s = dig_valid & dig_ready;
        last_digit_s = (count_r == LAST_DIGIT);
        term_s       = mc_r << count_r;
        addend_s     = digit_term(dig_h, dig_d, term_s);
        acc_next_s   = acc_r + addend_s;
    end

    // Control FSM with registered handshake/status outputs and the datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            count_r   <= {CW{1'b0}};
            acc_r     <= {W{1'b0}};
            mc_r      <= {W{1'b0}};
            prod      <= {W{1'b0}};
            dig_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef BOOTH_ERR_EN
            err       <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mc_r      <= {{M{multiplicand[N-1]}}, multiplicand};
                        acc_r     <= {W{1'b0}};
                        count_r   <= {CW{1'b0}};
                        dig_ready <= 1'b1;
                        busy      <= 1'b1;
                        state_r   <= ST_RUN;
`ifdef BOOTH_ERR_EN
                        err       <= 1'b0;
`endif
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (dig_accept_s) begin
                        acc_r <= acc_next_s;
`ifdef BOOTH_ERR_EN
                        if (!dig_h && dig_d) begin
                            err <= 1'b1;
                        end else begin
                            err <= err;
                        end
`endif
                        // The count stops at the last digit so it never wraps.
                        if (last_digit_s) begin
                            prod      <= acc_next_s;
                            dig_ready <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state_r   <= ST_DONE;
                        end else begin
                            count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    dig_ready <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_digit_accumulator.sv
// Directed self-checking bench for booth_digit_accumulator (3x3 Booth product).
module tb_booth_digit_accumulator;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] multiplicand;
    logic       dig_valid;
    logic       dig_h;
    logic       dig_d;
    logic       dig_ready;
    logic       busy;
    logic       done;
    logic [5:0] prod;
`ifdef BOOTH_ERR_EN
    logic       err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    booth_digit_accumulator #(.N(3), .M(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .dig_valid    (dig_valid),
        .dig_h        (dig_h),
        .dig_d        (dig_d),
        .dig_ready    (dig_ready),
        .busy         (busy),
        .done         (done),
`ifdef BOOTH_ERR_EN
        .err          (err),
`endif
        .prod         (prod)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // digs[1:0] is digit 0 as {H,D}; stall idles dig_valid before each digit.
    task automatic run_product(input string tag, input logic [2:0] mc, input logic [5:0] digs,
                               input int stall, input bit poke_start, input logic [5:0] exp);
        @(negedge clk);
        start        = 1'b1;
        multiplicand = mc;
        @(negedge clk);
        start        = 1'b0;
        multiplicand = ~mc;
        check_value({tag, "_busy_run"},  16'(busy), 16'h1);
        check_value({tag, "_ready_run"}, 16'(dig_ready), 16'h1);
        for (int i = 0; i < 3; i++) begin
            dig_valid = 1'b0;
            for (int s = 0; s < stall; s++) begin
                if (poke_start) start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            dig_valid = 1'b1;
            dig_h     = digs[2*i+1];
            dig_d     = digs[2*i];
            @(negedge clk);
            if (i < 2) check_value({tag, "_no_early_done"}, 16'(done), 16'h0);
        end
        dig_valid = 1'b0;
        dig_h     = 1'b0;
        dig_d     = 1'b0;
        check_value({tag, "_done"},      16'(done), 16'h1);
        check_value({tag, "_prod"},      16'(prod), 16'(exp));
        check_value({tag, "_busy_done"}, 16'(busy), 16'h0);
        check_value({tag, "_ready_done"}, 16'(dig_ready), 16'h0);
        @(negedge clk);
        check_value({tag, "_done_pulse"}, 16'(done), 16'h0);
        check_value({tag, "_prod_hold"},  16'(prod), 16'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n        = 1'b0;
        start        = 1'($urandom);
        multiplicand = 3'($urandom);
        dig_valid    = 1'($urandom);
        dig_h        = 1'($urandom);
        dig_d        = 1'($urandom);
        repeat (3) @(negedge clk);
        check_value("rst_prod",  16'(prod), 16'h0);
        check_value("rst_done",  16'(done), 16'h0);
        check_value("rst_busy",  16'(busy), 16'h0);
        check_value("rst_ready", 16'(dig_ready), 16'h0);
        start     = 1'b0;
        dig_valid = 1'b0;
        dig_h     = 1'b0;
        dig_d     = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);

        run_product("basic",   3'd3,    6'b10_00_11, 0, 1'b0, 6'h09);
        run_product("neg_mc",  3'b100,  6'b10_00_11, 0, 1'b0, 6'h34);
        run_product("neg_mul", 3'b100,  6'b11_00_00, 0, 1'b0, 6'h10);
        run_product("m1_pos",  3'b111,  6'b10_10_10, 0, 1'b0, 6'h39);
        run_product("max_mag", 3'b100,  6'b11_11_11, 0, 1'b0, 6'h1C);
        run_product("stall",   3'd3,    6'b10_00_11, 2, 1'b1, 6'h09);

        // Digits offered while idle must be ignored.
        dig_valid = 1'b1;
        dig_h     = 1'b1;
        dig_d     = 1'b1;
        repeat (3) @(negedge clk);
        check_value("idle_prod",  16'(prod), 16'h09);
        check_value("idle_busy",  16'(busy), 16'h0);
        check_value("idle_ready", 16'(dig_ready), 16'h0);
        dig_valid = 1'b0;
        dig_h     = 1'b0;
        dig_d     = 1'b0;

        run_product("illegal", 3'd3, 6'b10_01_10, 0, 1'b0, 6'h0F);
`ifdef BOOTH_ERR_EN
        check_value("err_set", 16'(err), 16'h1);
        @(negedge clk);
        check_value("err_sticky", 16'(err), 16'h1);
`endif

        // Abort mid-product after two digits.
        start        = 1'b1;
        multiplicand = 3'd2;
        @(negedge clk);
        start = 1'b0;
`ifdef BOOTH_ERR_EN
        check_value("err_clr", 16'(err), 16'h0);
`endif
        for (int i = 0; i < 2; i++) begin
            dig_valid = 1'b1;
            dig_h     = 1'b1;
            dig_d     = 1'b0;
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check_value("abort_prod",  16'(prod), 16'h0);
        check_value("abort_busy",  16'(busy), 16'h0);
        check_value("abort_ready", 16'(dig_ready), 16'h0);
        check_value("abort_done",  16'(done), 16'h0);
        dig_valid = 1'b0;
        dig_h     = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_product("post_abort", 3'd3, 6'b10_00_11, 0, 1'b0, 6'h09);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
